// File: rtl/ppfifo_write_arbiter.sv
// ppfifo_write_arbiter: round-robin arbiter that lets two burst producers share the write side of one ping-pong FIFO.
// Optional build macro PPFIFO_WR_ARB_TIMEOUT_EN adds a TIMEOUT-cycle idle release of partially filled buffers.
`default_nettype none

module ppfifo_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req0,
  input  logic                  i_strobe0,
  input  logic [DATA_WIDTH-1:0] i_data0,
  input  logic                  i_last0,
  output logic                  o_grant0,
  output logic                  o_ready0,
  input  logic                  i_req1,
  input  logic                  i_strobe1,
  input  logic [DATA_WIDTH-1:0] i_data1,
  input  logic                  i_last1,
  output logic                  o_grant1,
  output logic                  o_ready1,
  input  logic [1:0]            i_write_ready,
  input  logic [23:0]           i_write_fifo_size,
  output logic [1:0]            o_write_activate,
  output logic                  o_write_strobe,
  output logic [DATA_WIDTH-1:0] o_write_data
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACTIVATE = 3'd1,
    XFER     = 3'd2,
    RELEASE  = 3'd3,
    SWAP     = 3'd4
  } state_t;

  state_t                  state, state_nxt;
  logic [1:0]              grant, grant_nxt;
  logic [1:0]              activate, activate_nxt;
  logic                    write_strobe, write_strobe_nxt;
  logic [DATA_WIDTH-1:0]   write_data, write_data_nxt;
  logic [23:0]             count, count_nxt;
  logic                    owner, owner_nxt;
  logic                    last_owner, last_owner_nxt;
  logic                    cur_buf, cur_buf_nxt;

  logic                    ready0, ready1;
  logic                    sel_req, sel_strobe, sel_last, sel_ready;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    accept;
  logic [23:0]             count_inc;
  logic                    timeout_hit;
  logic                    pick;

  assign ready0 = (state == XFER) && grant[0] && (count < i_write_fifo_size);
  assign ready1 = (state == XFER) && grant[1] && (count < i_write_fifo_size);

  assign sel_req    = owner ? i_req1    : i_req0;
  assign sel_strobe = owner ? i_strobe1 : i_strobe0;
  assign sel_last   = owner ? i_last1   : i_last0;
  assign sel_data   = owner ? i_data1   : i_data0;
  assign sel_ready  = owner ? ready1    : ready0;
  assign accept     = sel_ready && sel_strobe;
  assign count_inc  = count + 24'd1;

  // Tie goes to whoever was not served last; a sole requester always wins.
  assign pick = (i_req0 && i_req1) ? ~last_owner : i_req1;

`ifdef PPFIFO_WR_ARB_TIMEOUT_EN
  logic [15:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if ((state != XFER) || accept) begin
      idle_cnt <= '0;
    end else if (count != 24'd0) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  assign timeout_hit = (state == XFER) && !accept && (count != 24'd0) &&
                       ((idle_cnt + 16'd1) == TIMEOUT_LIMIT);
`else
  // Idle release compiled out; TIMEOUT only shapes the optional counter.
  assign timeout_hit = 1'b0 && (TIMEOUT_LIMIT != 16'd0);
`endif

  always_comb begin
    state_nxt        = state;
    grant_nxt        = grant;
    activate_nxt     = activate;
    write_strobe_nxt = 1'b0;
    write_data_nxt   = write_data;
    count_nxt        = count;
    owner_nxt        = owner;
    last_owner_nxt   = last_owner;
    cur_buf_nxt      = cur_buf;

    case (state)
      IDLE: begin
        if ((i_req0 || i_req1) && (i_write_ready != 2'b00)) begin
          cur_buf_nxt  = ~i_write_ready[0];
          activate_nxt = i_write_ready[0] ? 2'b01 : 2'b10;
          owner_nxt    = pick;
          grant_nxt    = pick ? 2'b10 : 2'b01;
          state_nxt    = ACTIVATE;
        end
      end

      ACTIVATE: begin
        count_nxt = '0;
        state_nxt = XFER;
      end

      XFER: begin
        if (accept) begin
          write_strobe_nxt = 1'b1;
          write_data_nxt   = sel_data;
          count_nxt        = count_inc;
          if (sel_last || !sel_req) begin
            grant_nxt = 2'b00;
            state_nxt = RELEASE;
          end else if (count_inc >= i_write_fifo_size) begin
            state_nxt = SWAP;
          end
        end else if (!sel_req) begin
          grant_nxt = 2'b00;
          state_nxt = RELEASE;
        end else if (count >= i_write_fifo_size) begin
          // An empty buffer with nothing to hold is released rather than swapped.
          if (count == 24'd0) begin
            grant_nxt = 2'b00;
            state_nxt = RELEASE;
          end else begin
            state_nxt = SWAP;
          end
        end else if (timeout_hit) begin
          state_nxt = SWAP;
        end
      end

      RELEASE: begin
        activate_nxt   = 2'b00;
        last_owner_nxt = owner;
        state_nxt      = IDLE;
      end

      SWAP: begin
        if (activate != 2'b00) begin
          activate_nxt = 2'b00;
        end else if (i_write_ready[0] && (i_write_ready[1] || cur_buf)) begin
          activate_nxt = 2'b01;
          cur_buf_nxt  = 1'b0;
          state_nxt    = ACTIVATE;
        end else if (i_write_ready[1] && !cur_buf) begin
          activate_nxt = 2'b10;
          cur_buf_nxt  = 1'b1;
          state_nxt    = ACTIVATE;
        end
      end

      default: begin
        grant_nxt    = 2'b00;
        activate_nxt = 2'b00;
        state_nxt    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant        <= 2'b00;
      activate     <= 2'b00;
      write_strobe <= 1'b0;
      write_data   <= '0;
      count        <= '0;
      owner        <= 1'b0;
      last_owner   <= 1'b1;
      cur_buf      <= 1'b0;
    end else begin
      state        <= state_nxt;
      grant        <= grant_nxt;
      activate     <= activate_nxt;
      write_strobe <= write_strobe_nxt;
      write_data   <= write_data_nxt;
      count        <= count_nxt;
      owner        <= owner_nxt;
      last_owner   <= last_owner_nxt;
      cur_buf      <= cur_buf_nxt;
    end
  end

  assign o_grant0         = grant[0];
  assign o_grant1         = grant[1];
  assign o_ready0         = ready0;
  assign o_ready1         = ready1;
  assign o_write_activate = activate;
  assign o_write_strobe   = write_strobe;
  assign o_write_data     = write_data;

endmodule

`default_nettype wire
